// File: rtl/decoder.sv
// ---------------------------------------------------------------------------
// decoder
//   1-to-2 data demultiplexer. A WIDTH-bit word on `in` is routed to out0
//   (control=0) or out1 (control=1); the unselected channel is driven to zero.
//
//   Default build: outputs are registered on the rising edge of clk, with a
//   synchronous active-high rst that clears both channels and takes priority
//   over in/control.
//
//   Optional macro DECODER_COMB_OUT_EN: output registers are removed and
//   out0/out1 become pure combinational functions of in and control. clk and
//   rst stay on the port list but have no effect in this build.
//
// Ports
//   clk      in   1      clock, rising-edge active
//   rst      in   1      synchronous reset, active-high
//   in       in   WIDTH  data word to route
//   control  in   1      channel select: 0 -> out0, 1 -> out1
//   out0     out  WIDTH  channel 0 data, zero when not selected
//   out1     out  WIDTH  channel 1 data, zero when not selected
// ---------------------------------------------------------------------------
module decoder #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic             control,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1
);

  // Routing shared by both builds; only one channel ever carries the word,
  // so at least one output is all zeros at any time.
  logic [WIDTH-1:0] route0;
  logic [WIDTH-1:0] route1;

  always_comb begin
    route0 = '0;
    route1 = '0;
    if (control) route1 = in;
    else         route0 = in;
  end

`ifdef DECODER_COMB_OUT_EN

  // clk/rst are kept for a stable port list; fold them into a sink so the
  // unused inputs are explicit.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  assign out0 = route0;
  assign out1 = route1;

`else

  always_ff @(posedge clk) begin
    if (rst) begin
      out0 <= '0;
      out1 <= '0;
    end else begin
      out0 <= route0;
      out1 <= route1;
    end
  end

`endif

endmodule

// File: tb/tb_decoder.sv
module tb_decoder;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in;
  logic             control;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;

  int checks = 0;
  int errors = 0;

  decoder #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .control (control),
    .out0    (out0),
    .out1    (out1)
  );

  always #5 clk = ~clk;

  // Reference: the selected channel carries the word, the other is zero;
  // reset (registered build only) zeroes both.
  logic [WIDTH-1:0] exp0;
  logic [WIDTH-1:0] exp1;

  task automatic model(input logic r, input logic [WIDTH-1:0] d, input logic c);
`ifdef DECODER_COMB_OUT_EN
    r = 1'b0;
`endif
    if (r) begin
      exp0 = 0;
      exp1 = 0;
    end else begin
      exp0 = (c == 1'b0) ? d : 0;
      exp1 = (c == 1'b1) ? d : 0;
    end
  endtask

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs away from the clock edge, then compare outputs
  // one cycle later (registered) or within the same time step (comb).
  task automatic step(input string tag, input logic r,
                      input logic [WIDTH-1:0] d, input logic c);
    @(negedge clk);
    rst     = r;
    in      = d;
    control = c;
`ifdef DECODER_COMB_OUT_EN
    #1;
`else
    @(posedge clk);
    #1;
`endif
    model(r, d, c);
    check({tag, ".out0"}, out0, exp0);
    check({tag, ".out1"}, out1, exp1);
    checks++;
    assert (((out0 == 0) || (out1 == 0)) === 1'b1)
    else begin
      errors++;
      $error("FAIL %s.onehot: observed out0=%h out1=%h expected one zero", tag, out0, out1);
    end
  endtask

  initial begin
    rst     = 1'b1;
    in      = 32'hAAAA5555;
    control = 1'b0;

    // Reset held for two cycles
    step("reset_a", 1'b1, 32'hAAAA5555, 1'b0);
    step("reset_b", 1'b1, 32'hAAAA5555, 1'b0);

    // Routing after release
    step("route0",  1'b0, 32'hAAAA5555, 1'b0);
    step("route1",  1'b0, 32'hAAAA5555, 1'b1);
    step("b2b_0",   1'b0, 32'h12345678, 1'b0);
    step("b2b_1",   1'b0, 32'h87654321, 1'b1);

    // Mid-stream reset, then resume
    step("mid_rst", 1'b1, 32'h87654321, 1'b1);
    step("resume0", 1'b0, 32'hDEADBEEF, 1'b0);
    step("resume1", 1'b0, 32'hCAFEF00D, 1'b1);

    // Boundary words
    step("zero_in", 1'b0, 32'h00000000, 1'b1);
    step("ones_0",  1'b0, 32'hFFFFFFFF, 1'b0);
    step("ones_1",  1'b0, 32'hFFFFFFFF, 1'b1);

    // Reset overriding a non-zero word on channel 0
    step("rst_pri", 1'b1, 32'hFFFFFFFF, 1'b0);

    // Randomized traffic with occasional resets and zero words
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] d;
      logic             c;
      logic             r;
      d = ($urandom_range(0, 9) == 0) ? 32'h0 : $urandom;
      c = 1'(($urandom_range(0, 1)));
      r = ($urandom_range(0, 15) == 0);
      step("rand", r, d, c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
